long_division_axi4s: RTL and testbench

Fixed-point signed divider serving as the responder on the long-division AXI4-Stream interface used by the oscillator cores. It accepts a two-beat request: dividend first with tlast=0, then divisor with tlast=1. It computes a truncated Q-format quotient with a serial restoring algorithm, one quotient bit per clock. It returns a single-beat response carrying the requester's tid and an overflow flag in tuser.

---
 rtl/long_division_axi4s_if.sv | 16 +
 rtl/long_division_axi4s.sv | 164 ++++++++++++++++
 tb/tb_long_division_axi4s.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/long_division_axi4s_if.sv
// AXI4-Stream bundle shared by the long-division requester and responder.
// The ingress side carries no tuser, so the slave modport leaves it out.
interface long_division_axi4s_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic              tuser;

  modport master (output tvalid, tdata, tlast, tid, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, output tready);
endinterface

// File: rtl/long_division_axi4s.sv
// Serial restoring signed Q-format divider behind an AXI4-Stream request/response pair.
// state          | meaning
// IDLE_E         | waiting for the dividend beat (a stray divisor beat is dropped)
// WAIT_DIVISOR_E | dividend held, waiting for the divisor beat
// PREP_E         | take magnitudes, result sign, divide-by-zero flag
// DIVIDE_E       | one quotient bit per clock, MSB first
// SEND_E         | load the saturated result, then hold it until accepted
module long_division_axi4s #(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_ID_WIDTH_P   = 4,
  parameter int N_BITS_P         = 32,
  parameter int Q_BITS_P         = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  long_division_axi4s_if.slave   ing,
  long_division_axi4s_if.master  egr
);
  localparam int N  = N_BITS_P;
  localparam int W  = N_BITS_P + Q_BITS_P;
  localparam int CW = $clog2(W);
  localparam logic [N-1:0] POS_SAT = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_SAT = {1'b1, {(N-1){1'b0}}};
  localparam logic [W-1:0] LIM_POS = W'(POS_SAT);
  localparam logic [W-1:0] LIM_NEG = LIM_POS + 1'b1;

  typedef enum logic [2:0] {
    IDLE_E, WAIT_DIVISOR_E, PREP_E, DIVIDE_E, SEND_E
  } state_t;

  state_t r_state, w_next;

  logic [N-1:0]                r_dividend, r_divisor, r_dvs_mag;
  logic [AXI_ID_WIDTH_P-1:0]   r_tid;
  logic                        r_neg, r_dvd_neg, r_div0;
  logic [W-1:0]                r_num, r_quo;
  logic [N:0]                  r_rem;
  logic [CW-1:0]               r_cnt;
  logic                        r_ing_tready;
  logic                        r_egr_tvalid, r_egr_tlast, r_egr_tuser;
  logic [AXI_DATA_WIDTH_P-1:0] r_egr_tdata;
  logic [AXI_ID_WIDTH_P-1:0]   r_egr_tid;

  logic         w_ing_hs, w_egr_hs;
  logic [N-1:0] w_dvd_mag, w_dvs_mag, w_q_n, w_q_s, w_res;
  logic [N+1:0] w_rem_sh;
  logic [N:0]   w_sub;
  logic         w_ge, w_ovf, w_res_flag;

  assign w_ing_hs = ing.tvalid & r_ing_tready;
  assign w_egr_hs = r_egr_tvalid & egr.tready;

  assign w_dvd_mag = r_dividend[N-1] ? (~r_dividend + 1'b1) : r_dividend;
  assign w_dvs_mag = r_divisor[N-1]  ? (~r_divisor + 1'b1)  : r_divisor;

  // Remainder stays below the divisor, so the shifted value never needs more than N+1 bits.
  assign w_rem_sh = {r_rem, r_num[W-1]};
  assign w_ge     = (w_rem_sh >= {2'b00, r_dvs_mag});
  assign w_sub    = w_rem_sh[N:0] - {1'b0, r_dvs_mag};

  assign w_q_n = r_quo[N-1:0];
  assign w_q_s = r_neg ? (~w_q_n + 1'b1) : w_q_n;
  assign w_ovf = r_neg ? (r_quo > LIM_NEG) : (r_quo > LIM_POS);

  always_comb begin
    w_res      = w_q_s;
    w_res_flag = 1'b0;
    if (r_div0) begin
      w_res      = r_dvd_neg ? NEG_SAT : POS_SAT;
      w_res_flag = 1'b1;
    end else if (w_ovf) begin
      w_res      = r_neg ? NEG_SAT : POS_SAT;
      w_res_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE_E;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE_E:         if (w_ing_hs && !ing.tlast) w_next = WAIT_DIVISOR_E;
      WAIT_DIVISOR_E: if (w_ing_hs && ing.tlast)  w_next = PREP_E;
      PREP_E:         w_next = DIVIDE_E;
      DIVIDE_E:       if (r_cnt == '0) w_next = SEND_E;
      SEND_E:         if (w_egr_hs) w_next = IDLE_E;
      default:        w_next = IDLE_E;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_dvs_mag    <= '0;
      r_tid        <= '0;
      r_neg        <= 1'b0;
      r_dvd_neg    <= 1'b0;
      r_div0       <= 1'b0;
      r_num        <= '0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_ing_tready <= 1'b0;
      r_egr_tvalid <= 1'b0;
      r_egr_tlast  <= 1'b0;
      r_egr_tuser  <= 1'b0;
      r_egr_tdata  <= '0;
      r_egr_tid    <= '0;
    end else begin
      // Ready is a registered copy of "next state takes input".
      r_ing_tready <= (w_next == IDLE_E) || (w_next == WAIT_DIVISOR_E);
      case (r_state)
        IDLE_E, WAIT_DIVISOR_E: begin
          if (w_ing_hs && !ing.tlast) begin
            r_dividend <= ing.tdata[N-1:0];
            r_tid      <= ing.tid;
          end else if (w_ing_hs && (r_state == WAIT_DIVISOR_E)) begin
            r_divisor <= ing.tdata[N-1:0];
          end
        end
        PREP_E: begin
          r_neg     <= r_dividend[N-1] ^ r_divisor[N-1];
          r_dvd_neg <= r_dividend[N-1];
          r_div0    <= (r_divisor == '0);
          r_dvs_mag <= w_dvs_mag;
          r_num     <= W'(w_dvd_mag) << Q_BITS_P;
          r_quo     <= '0;
          r_rem     <= '0;
          r_cnt     <= CW'(W - 1);
        end
        DIVIDE_E: begin
          r_rem <= w_ge ? w_sub : w_rem_sh[N:0];
          r_num <= r_num << 1;
          r_quo <= {r_quo[W-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        SEND_E: begin
          if (!r_egr_tvalid) begin
            r_egr_tvalid <= 1'b1;
            r_egr_tlast  <= 1'b1;
            r_egr_tuser  <= w_res_flag;
            r_egr_tdata  <= AXI_DATA_WIDTH_P'(signed'(w_res));
            r_egr_tid    <= r_tid;
          end else if (egr.tready) begin
            r_egr_tvalid <= 1'b0;
            r_egr_tlast  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ing.tready = r_ing_tready;
  assign egr.tvalid = r_egr_tvalid;
  assign egr.tdata  = r_egr_tdata;
  assign egr.tlast  = r_egr_tlast;
  assign egr.tid    = r_egr_tid;
  assign egr.tuser  = r_egr_tuser;
endmodule

// File: tb/tb_long_division_axi4s.sv
// Directed bench for long_division_axi4s with N=32, Q=11; expected quotients are hand-computed.
module tb_long_division_axi4s;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  long_division_axi4s_if #(.DATA_W(DW), .ID_W(IW)) ing_if ();
  long_division_axi4s_if #(.DATA_W(DW), .ID_W(IW)) egr_if ();

  long_division_axi4s #(
    .AXI_DATA_WIDTH_P(DW), .AXI_ID_WIDTH_P(IW), .N_BITS_P(32), .Q_BITS_P(11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ing(ing_if), .egr(egr_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] data, input logic last, input logic [IW-1:0] id);
    int n;
    @(negedge clk);
    ing_if.tvalid = 1'b1;
    ing_if.tdata  = data;
    ing_if.tlast  = last;
    ing_if.tid    = id;
    n = 0;
    while (ing_if.tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ing_tready_timeout", 64'(ing_if.tready), 64'd1);
    @(posedge clk);
    #1;
    ing_if.tvalid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (egr_if.tvalid === 1'b1) break;
    end
  endtask

  task automatic take_resp(input string tag, input logic [31:0] exp_data,
                           input logic exp_user, input logic [IW-1:0] exp_id);
    check({tag, "_tvalid"}, 64'(egr_if.tvalid), 64'd1);
    check({tag, "_tdata"},  64'(egr_if.tdata),  64'(exp_data));
    check({tag, "_tuser"},  64'(egr_if.tuser),  64'(exp_user));
    check({tag, "_tid"},    64'(egr_if.tid),    64'(exp_id));
    check({tag, "_tlast"},  64'(egr_if.tlast),  64'd1);
    @(negedge clk);
    egr_if.tready = 1'b1;
    @(posedge clk);
    #1;
    egr_if.tready = 1'b0;
    check({tag, "_tvalid_drop"}, 64'(egr_if.tvalid), 64'd0);
    check({tag, "_ready_back"},  64'(ing_if.tready), 64'd1);
  endtask

  task automatic run_case(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic [IW-1:0] id, input logic [31:0] exp_data,
                          input logic exp_user);
    int lat;
    send_beat(dvd, 1'b0, id);
    send_beat(dvs, 1'b1, id);
    check({tag, "_ready_low"}, 64'(ing_if.tready), 64'd0);
    wait_valid(lat);
    check({tag, "_latency"}, 64'(lat), 64'd45);
    take_resp(tag, exp_data, exp_user, id);
  endtask

  initial begin
    int lat;
    logic stable, seen;
    ing_if.tvalid = 1'b0;
    ing_if.tdata  = '0;
    ing_if.tlast  = 1'b0;
    ing_if.tid    = '0;
    ing_if.tuser  = 1'b0;
    egr_if.tready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ing_tready", 64'(ing_if.tready), 64'd0);
    check("rst_egr_tvalid", 64'(egr_if.tvalid), 64'd0);
    check("rst_egr_tdata",  64'(egr_if.tdata),  64'd0);
    check("rst_egr_tlast",  64'(egr_if.tlast),  64'd0);
    check("rst_egr_tid",    64'(egr_if.tid),    64'd0);
    check("rst_egr_tuser",  64'(egr_if.tuser),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(ing_if.tready), 64'd1);

    run_case("osc",     32'h7A120000, 32'h001F4000, 4'd3, 32'h001F4000, 1'b0);
    run_case("neg_1p5", 32'hFFFFE800, 32'h00001000, 4'd1, 32'hFFFFF400, 1'b0);
    run_case("third",   32'h00000800, 32'h00001800, 4'd2, 32'h000002AA, 1'b0);
    run_case("nthird",  32'hFFFFF800, 32'h00001800, 4'd4, 32'hFFFFFD56, 1'b0);
    run_case("neg_dvs", 32'h00001800, 32'hFFFFF000, 4'd5, 32'hFFFFF400, 1'b0);
    run_case("ovf_pos", 32'h40000000, 32'h00000001, 4'd6, 32'h7FFFFFFF, 1'b1);
    run_case("ovf_neg", 32'hC0000000, 32'h00000001, 4'd7, 32'h80000000, 1'b1);
    run_case("dz_pos",  32'h00002800, 32'h00000000, 4'd8, 32'h7FFFFFFF, 1'b1);
    run_case("dz_neg",  32'hFFFFD800, 32'h00000000, 4'd9, 32'h80000000, 1'b1);

    // Backpressure: 2.0 / 1.0 = 2.0 held for 20 cycles
    send_beat(32'h00001000, 1'b0, 4'd10);
    send_beat(32'h00000800, 1'b1, 4'd10);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd45);
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (egr_if.tvalid !== 1'b1 || egr_if.tdata !== 32'h00001000 || egr_if.tid !== 4'd10 ||
          egr_if.tuser !== 1'b0 || ing_if.tready !== 1'b0)
        stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    take_resp("bp", 32'h00001000, 1'b0, 4'd10);

    // Lone divisor beat in idle is dropped
    send_beat(32'h00001234, 1'b1, 4'd2);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (egr_if.tvalid === 1'b1) seen = 1'b1;
    end
    check("lone_tlast_no_resp", 64'(seen), 64'd0);
    check("lone_tlast_ready",   64'(ing_if.tready), 64'd1);

    // Second dividend replaces the first: 1.0 / 2.0 = 0.5 with tid 6
    send_beat(32'h00001800, 1'b0, 4'd5);
    send_beat(32'h00000800, 1'b0, 4'd6);
    send_beat(32'h00001000, 1'b1, 4'd6);
    wait_valid(lat);
    check("redvd_latency", 64'(lat), 64'd45);
    take_resp("redvd", 32'h00000400, 1'b0, 4'd6);

    // Reset ten cycles into the divide
    send_beat(32'h00002800, 1'b0, 4'd11);
    send_beat(32'h00001000, 1'b1, 4'd11);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs",
          64'({ing_if.tready, egr_if.tvalid, egr_if.tlast, egr_if.tuser, egr_if.tid, egr_if.tdata}),
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (egr_if.tvalid === 1'b1) seen = 1'b1;
    end
    check("midrst_no_resp", 64'(seen), 64'd0);
    run_case("post_rst", 32'h00002800, 32'h00001000, 4'd7, 32'h00001400, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
